// File: rtl/aes_pkg.sv
// AES-128 shared constants, FSM encoding and GF(2^8) round helper functions.
// Latency: none, combinational helpers and constants only.
// Backpressure: not applicable.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } aes_fsm_t;

  // Round constants for rounds 1..10, round 1 in the top byte.
  localparam logic [79:0] RCON = 80'h01_02_04_08_10_20_40_80_1b_36;

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for round r; zero outside 1..NR so idle cycles stay defined.
  function automatic logic [7:0] get_rcon(input logic [3:0] r);
    logic [7:0] rc;
    rc = 8'h00;
    if (r >= 4'd1 && r <= 4'(NR)) rc = RCON[8*(NR - int'(r)) +: 8];
    return rc;
  endfunction

  // One state column, row 0 in the top byte.
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte 4*c+r is row r of column c; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES forward S-box lookup.
// Latency: combinational.
// Backpressure: not applicable.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_val,
  output logic [7:0] sub_byte
);

  assign sub_byte = SBOX[8*(255 - int'(byte_val)) +: 8];

endmodule

// File: rtl/aes_top.sv
// Iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
// Latency: result valid 10 clocks after the capture edge; one result per 11 clocks when held enabled.
// Backpressure: none; AES_en is sampled only in IDLE. Optional ports: AES_DATA_OUT_COMPLEMENTARY_EN.
module aes_top
  import aes_pkg::*;
(
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
`ifdef AES_DATA_OUT_COMPLEMENTARY_EN
  ,
  output logic [127:0] AES_data_out_complementary,
  output logic         AES_data_out_complementary_valid
`endif
);

  aes_fsm_t     fsm_q, fsm_d;
  logic [127:0] state_q;
  logic [127:0] round_key_q;
  logic [3:0]   round_cnt_q;

  logic         load, step, last;
  logic [127:0] sb, sr, mc, round_out, next_rk;
  logic [31:0]  rot_w3, sub_rot, key_tmp;
  logic [31:0]  nw0, nw1, nw2, nw3;

  // SubBytes on the whole state.
  for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
    aes_sbox u_sbox (
      .byte_val (state_q[127 - 8*i -: 8]),
      .sub_byte (sb[127 - 8*i -: 8])
    );
  end

  // SubWord(RotWord(w3)) for the key schedule.
  assign rot_w3 = {round_key_q[23:0], round_key_q[31:24]};
  for (genvar j = 0; j < 4; j++) begin : g_sub_word
    aes_sbox u_sbox (
      .byte_val (rot_w3[31 - 8*j -: 8]),
      .sub_byte (sub_rot[31 - 8*j -: 8])
    );
  end

  // Next round key from the current one.
  always_comb begin
    key_tmp = sub_rot ^ {get_rcon(round_cnt_q), 24'h000000};
    nw0     = round_key_q[127:96] ^ key_tmp;
    nw1     = round_key_q[95:64]  ^ nw0;
    nw2     = round_key_q[63:32]  ^ nw1;
    nw3     = round_key_q[31:0]   ^ nw2;
    next_rk = {nw0, nw1, nw2, nw3};
  end

  // Round function; the final round skips MixColumns.
  always_comb begin
    sr = shift_rows(sb);
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      mc[127 - 32*c -: 32] = mix_column(sr[127 - 32*c -: 32]);
    end
    round_out = ((round_cnt_q == 4'(NR)) ? sr : mc) ^ next_rk;
  end

  // FSM state register.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) fsm_q <= IDLE;
    else            fsm_q <= fsm_d;
  end

  // Next-state and datapath controls.
  always_comb begin
    fsm_d = fsm_q;
    load  = 1'b0;
    step  = 1'b0;
    last  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (AES_en) begin
          load  = 1'b1;
          fsm_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (round_cnt_q == 4'(NR)) begin
          last  = 1'b1;
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Cipher state, round key, round counter and result registers.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q            <= '0;
      round_key_q        <= '0;
      round_cnt_q        <= '0;
      AES_data_out       <= '0;
      AES_data_out_valid <= 1'b0;
    end else begin
      AES_data_out_valid <= last;
      if (load) begin
        state_q     <= AES_data_in ^ AES_key_in;
        round_key_q <= AES_key_in;
        round_cnt_q <= 4'd1;
      end else if (step) begin
        state_q     <= round_out;
        round_key_q <= next_rk;
        round_cnt_q <= last ? 4'd0 : round_cnt_q + 4'd1;
      end
      if (last) AES_data_out <= round_out;
    end
  end

`ifdef AES_DATA_OUT_COMPLEMENTARY_EN
  assign AES_data_out_complementary       = ~AES_data_out;
  assign AES_data_out_complementary_valid = AES_data_out_valid;
`endif

endmodule

// File: tb/tb_aes_top.sv
// Self-checking bench for aes_top: FIPS vectors, random vectors against a byte-level model.
// Latency: checks the 10-clock result latency and the 11-clock held-enable period.
// Backpressure: not applicable.
module tb_aes_top;

  logic         AES_clk = 1'b0;
  logic         AES_rst_n = 1'b0;
  logic         AES_en = 1'b0;
  logic [127:0] AES_data_in = '0;
  logic [127:0] AES_key_in = '0;
  logic [127:0] AES_data_out;
  logic         AES_data_out_valid;
`ifdef AES_DATA_OUT_COMPLEMENTARY_EN
  logic [127:0] AES_data_out_complementary;
  logic         AES_data_out_complementary_valid;
`endif

  aes_top dut (
    .AES_clk            (AES_clk),
    .AES_rst_n          (AES_rst_n),
    .AES_en             (AES_en),
    .AES_data_in        (AES_data_in),
    .AES_key_in         (AES_key_in),
    .AES_data_out       (AES_data_out),
    .AES_data_out_valid (AES_data_out_valid)
`ifdef AES_DATA_OUT_COMPLEMENTARY_EN
    ,
    .AES_data_out_complementary       (AES_data_out_complementary),
    .AES_data_out_complementary_valid (AES_data_out_complementary_valid)
`endif
  );

  always #5 AES_clk = ~AES_clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sb_ref [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15 - n -: 8];
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s [16];
    logic [7:0] k [16];
    logic [7:0] t [16];
    logic [7:0] rc;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      s[i] = pt[127 - 8*i -: 8] ^ key[127 - 8*i -: 8];
      k[i] = key[127 - 8*i -: 8];
    end
    rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb_ref[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c + r] = s[4*((c + r) % 4) + r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          logic [7:0] a0, a1, a2, a3;
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          t[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
      end
      k[0] = k[0] ^ sb_ref[k[13]] ^ rc;
      k[1] = k[1] ^ sb_ref[k[14]];
      k[2] = k[2] ^ sb_ref[k[15]];
      k[3] = k[3] ^ sb_ref[k[12]];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = gmul(rc, 8'h02);
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge AES_clk);
    #1;
  endtask

  task automatic check_comp(input string name);
`ifdef AES_DATA_OUT_COMPLEMENTARY_EN
    check({name, "_comp"}, AES_data_out_complementary, ~AES_data_out);
    check({name, "_comp_vld"}, 128'(AES_data_out_complementary_valid), 128'(AES_data_out_valid));
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  // One-cycle enable pulse; expects the result exactly 10 clocks later, then hold.
  task automatic run_one(input string name, input logic [127:0] pt, input logic [127:0] key,
                         input logic [127:0] exp);
    int lat;
    bit got;
    AES_data_in = pt;
    AES_key_in  = key;
    AES_en      = 1'b1;
    tick();
    AES_en = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      tick();
      lat++;
      if (AES_data_out_valid) got = 1'b1;
    end
    check({name, "_lat"}, 128'(lat), 128'd10);
    check({name, "_dat"}, AES_data_out, exp);
    check_comp(name);
    tick();
    check({name, "_vld_drop"}, 128'(AES_data_out_valid), 128'd0);
    check({name, "_hold"}, AES_data_out, exp);
  endtask

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];

  initial begin
    logic [127:0] pt, key, exp, got_dat [$];
    int valid_at [$];
    int vcount;

    vecs[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    build_sbox();

    // Reset state.
    repeat (3) tick();
    check("rst_dat", AES_data_out, 128'h0);
    check("rst_vld", 128'(AES_data_out_valid), 128'd0);
`ifdef AES_DATA_OUT_COMPLEMENTARY_EN
    check("rst_comp", AES_data_out_complementary, {128{1'b1}});
    check("rst_comp_vld", 128'(AES_data_out_complementary_valid), 128'd0);
`endif
    AES_rst_n = 1'b1;

    // Idle with enable low: inputs ignored, no valid.
    AES_data_in = 128'h1234;
    AES_key_in  = 128'h5678;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (AES_data_out_valid) vcount++;
    end
    check("idle_no_vld", 128'(vcount), 128'd0);
    check("idle_dat", AES_data_out, 128'h0);

    // FIPS-197 vectors.
    for (int i = 0; i < 3; i++) run_one($sformatf("fips%0d", i), vecs[i].pt, vecs[i].key, vecs[i].ct);
`ifdef AES_DATA_OUT_COMPLEMENTARY_EN
    run_one("appb_c", vecs[0].pt, vecs[0].key, vecs[0].ct);
    check("appb_comp_val", AES_data_out_complementary, 128'hc6da7be2fd23f60423ee7a68e695f4cd);
`endif

    // Random vectors against the model.
    for (int i = 0; i < 8; i++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      run_one($sformatf("rnd%0d", i), pt, key, aes_ref(pt, key));
    end

    // Inputs and enable changing mid-run must not disturb the current result.
    pt  = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    exp = aes_ref(pt, key);
    AES_data_in = pt;
    AES_key_in  = key;
    AES_en      = 1'b1;
    tick();
    AES_en = 1'b0;
    vcount = 0;
    for (int k = 1; k <= 20 && vcount == 0; k++) begin
      tick();
      if (k == 3) begin
        AES_data_in = ~pt;
        AES_key_in  = ~key;
        AES_en      = 1'b1;
      end
      if (k == 5) AES_en = 1'b0;
      if (AES_data_out_valid) begin
        vcount = k;
        check("midrun_dat", AES_data_out, exp);
      end
    end
    check("midrun_lat", 128'(vcount), 128'd10);
    repeat (3) tick();

    // Held enable: one result every 11 clocks, identical ciphertext.
    AES_data_in = vecs[1].pt;
    AES_key_in  = vecs[1].key;
    AES_en      = 1'b1;
    for (int k = 0; k < 65; k++) begin
      tick();
      if (AES_data_out_valid) begin
        valid_at.push_back(k);
        got_dat.push_back(AES_data_out);
      end
      if (k == 50) AES_en = 1'b0;
    end
    check("held_count", 128'(valid_at.size()), 128'd5);
    for (int i = 0; i < valid_at.size() && i < 5; i++) begin
      check($sformatf("held_at%0d", i), 128'(valid_at[i]), 128'(10 + 11*i));
      check($sformatf("held_dat%0d", i), got_dat[i], vecs[1].ct);
    end

    // Reset during round 5 aborts with no pulse.
    AES_data_in = vecs[0].pt;
    AES_key_in  = vecs[0].key;
    AES_en      = 1'b1;
    tick();
    AES_en = 1'b0;
    repeat (4) tick();
    AES_rst_n = 1'b0;
    #1;
    check("abort_dat", AES_data_out, 128'h0);
    check("abort_vld", 128'(AES_data_out_valid), 128'd0);
`ifdef AES_DATA_OUT_COMPLEMENTARY_EN
    check("abort_comp", AES_data_out_complementary, {128{1'b1}});
`endif
    tick();
    tick();
    AES_rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (AES_data_out_valid) vcount++;
    end
    check("abort_no_vld", 128'(vcount), 128'd0);
    run_one("post_rst", vecs[0].pt, vecs[0].key, vecs[0].ct);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
